// File: rtl/us_cmd_pkg.sv
// Shared types and constants for the upstream command arbiter.
package us_cmd_pkg;

    localparam int US_CMD_DATA_W = 128;
    localparam int US_CMD_STAT_W = 16;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } us_cmd_arb_state_t;

endpackage

// File: rtl/us_cmd_arb_rr_pick.sv
// Combinational round-robin selector: first set request strictly after `last`,
// wrapping around; `any` is high when at least one request is set.
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last,
    output logic [$clog2(N)-1:0] idx,
    output logic                 any
);

    localparam int IDX_W = $clog2(N);

    // pos[k] is the requester examined k-th; rot holds its request bit.
    logic [IDX_W-1:0] pos [N];
    logic [N-1:0]     rot;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_rot
            assign pos[gi] = IDX_W'((int'(last) + 1 + gi) % N);
            assign rot[gi] = req[pos[gi]];
        end
    endgenerate

    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                idx = pos[k];
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/us_cmd_arb.sv
// Round-robin arbiter feeding the single write port of the upstream command FIFO.
// Optional per-requester accepted-command counters: define US_CMD_ARB_STATS_EN.
module us_cmd_arb
    import us_cmd_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = US_CMD_DATA_W,
    parameter int MAX_BURST = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [DATA_W-1:0]           fifo_din,
    output logic                        fifo_wr_en,
    input  logic                        fifo_full,
    input  logic                        fifo_prog_full,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic                        ovf_err
`ifdef US_CMD_ARB_STATS_EN
    ,
    output logic [NUM_REQ*US_CMD_STAT_W-1:0] stat_cnt
`endif
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int BC_W  = 4;

    us_cmd_arb_state_t state_reg, state_next;
    logic [IDX_W-1:0]  last_reg, last_next;
    logic [IDX_W-1:0]  grant_reg, grant_next;
    logic [BC_W-1:0]   burst_reg, burst_next;
    logic [DATA_W-1:0] din_reg;
    logic              wr_en_reg;
    logic              ovf_reg;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_any;
    logic              hs;
    logic [DATA_W-1:0] req_arr [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign req_arr[gi] = req_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    rr_pick #(.N(NUM_REQ)) u_pick (
        .req  (req_valid),
        .last (last_reg),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    // prog_full freezes the grant: no handshake, no release, even if the
    // granted requester has dropped valid meanwhile.
    always_comb begin
        state_next = state_reg;
        last_next  = last_reg;
        grant_next = grant_reg;
        burst_next = burst_reg;
        req_ready  = '0;
        hs         = 1'b0;
        case (state_reg)
            IDLE: begin
                if (pick_any && !fifo_prog_full) begin
                    grant_next = pick_idx;
                    burst_next = '0;
                    state_next = XFER;
                end
            end
            XFER: begin
                req_ready[grant_reg] = ~fifo_prog_full;
                hs = req_valid[grant_reg] & ~fifo_prog_full;
                if (!fifo_prog_full) begin
                    if (!req_valid[grant_reg]) begin
                        state_next = IDLE;
                        last_next  = grant_reg;
                    end else begin
                        burst_next = burst_reg + 1'b1;
                        if (burst_reg == BC_W'(MAX_BURST - 1)) begin
                            state_next = IDLE;
                            last_next  = grant_reg;
                        end
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            last_reg  <= IDX_W'(NUM_REQ - 1);
            grant_reg <= '0;
            burst_reg <= '0;
            din_reg   <= '0;
            wr_en_reg <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            last_reg  <= last_next;
            grant_reg <= grant_next;
            burst_reg <= burst_next;
            wr_en_reg <= hs;
            if (hs) begin
                din_reg <= req_arr[grant_reg];
            end
            if (wr_en_reg && fifo_full) begin
                ovf_reg <= 1'b1;
            end
        end
    end

    assign fifo_din   = din_reg;
    assign fifo_wr_en = wr_en_reg;
    assign grant_id   = grant_reg;
    assign ovf_err    = ovf_reg;

`ifdef US_CMD_ARB_STATS_EN
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stat
            logic [US_CMD_STAT_W-1:0] cnt_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg <= '0;
                end else if (hs && grant_reg == IDX_W'(gi)) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
            assign stat_cnt[gi*US_CMD_STAT_W +: US_CMD_STAT_W] = cnt_reg;
        end
    endgenerate
`endif

endmodule
